// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, synchronous write, sticky
// out-of-range write flag. Optional write-through forwarding via DATA_MEMORY_WR_FORWARD_EN.
module data_memory #(
   parameter int DEPTH = 256,
   parameter int AW    = 32
) (
   output logic [31:0]   ReadData,
   input  logic [AW-1:0] Address,
   input  logic [31:0]   WriteData,
   input  logic          MemWrite,
   input  logic          clk,
   input  logic          rst_n,
   output logic          addr_err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   reg [31:0] data [0:DEPTH-1];

   logic [63:0]   addr_ext_s;
   logic          in_range_s;
   logic [IW-1:0] idx_s;
   logic          wr_en_s;
   logic [31:0]   rd_data_s;
   logic          addr_err_d;
   logic          addr_err_q;

   // Address decode: the range test uses the full port width so high bits are never aliased
   always_comb begin
      addr_ext_s = 64'(Address);
      in_range_s = (addr_ext_s < 64'(DEPTH));
      idx_s      = Address[IW-1:0];
      wr_en_s    = MemWrite & rst_n & in_range_s;
   end

   // Combinational read; out-of-range addresses read as zero
   always_comb begin
      rd_data_s = 32'h0000_0000;
      if (in_range_s) begin
         rd_data_s = data[idx_s];
      end else begin
         rd_data_s = 32'h0000_0000;
      end
`ifdef DATA_MEMORY_WR_FORWARD_EN
      if (wr_en_s) begin
         rd_data_s = WriteData;
      end else begin
         rd_data_s = rd_data_s;
      end
`endif
   end

   assign ReadData = rd_data_s;

   // Array write; storage is deliberately not reset so preloaded contents survive
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         data[idx_s] <= WriteData;
      end
   end

   // Sticky error next-state: set by any attempted out-of-range write
   always_comb begin
      addr_err_d = addr_err_q;
      if (MemWrite && !in_range_s) begin
         addr_err_d = 1'b1;
      end else begin
         addr_err_d = addr_err_q;
      end
   end

   // Error flag register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= addr_err_d;
      end
   end

   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: reference array model plus expected-value queue.
module tb_data_memory;

   localparam int DEPTH = 256;
   localparam int AW    = 32;

   logic [31:0]   ReadData;
   logic [AW-1:0] Address;
   logic [31:0]   WriteData;
   logic          MemWrite;
   logic          clk;
   logic          rst_n;
   logic          addr_err;

   logic [31:0] mem_m [0:DEPTH-1];
   logic        err_m;
   logic [31:0] exp_q [$];
   int          n_tests;
   int          n_fail;

   data_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
      .ReadData (ReadData),
      .Address  (Address),
      .WriteData(WriteData),
      .MemWrite (MemWrite),
      .clk      (clk),
      .rst_n    (rst_n),
      .addr_err (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [AW-1:0] addr);
      if (addr < AW'(DEPTH)) return mem_m[addr[7:0]];
      return 32'h0000_0000;
   endfunction

   task automatic read_chk(input string tag, input logic [AW-1:0] addr);
      Address = addr;
      exp_q.push_back(model_rd(addr));
      #1;
      check_eq(tag, ReadData, exp_q.pop_front());
   endtask

   // One clock: drive, check before the edge (forwarding aware), update model, check after
   task automatic do_cycle(input string tag, input logic we, input logic [AW-1:0] addr,
                           input logic [31:0] wdata);
      logic in_rng;
      @(negedge clk);
      Address   = addr;
      WriteData = wdata;
      MemWrite  = we;
      in_rng    = (addr < AW'(DEPTH));
`ifdef DATA_MEMORY_WR_FORWARD_EN
      if (we && rst_n && in_rng) exp_q.push_back(wdata);
      else exp_q.push_back(model_rd(addr));
`else
      exp_q.push_back(model_rd(addr));
`endif
      #1;
      check_eq({tag, "_pre"}, ReadData, exp_q.pop_front());
      @(posedge clk);
      if (!rst_n) err_m = 1'b0;
      else begin
         if (we && in_rng) mem_m[addr[7:0]] = wdata;
         if (we && !in_rng) err_m = 1'b1;
      end
      #1;
      MemWrite = 1'b0;
      exp_q.push_back(model_rd(addr));
      #1;
      check_eq({tag, "_post"}, ReadData, exp_q.pop_front());
      check_eq({tag, "_err"}, {31'd0, addr_err}, {31'd0, err_m});
   endtask

   initial begin
      logic [31:0] a;
      n_tests   = 0;
      n_fail    = 0;
      err_m     = 1'b0;
      rst_n     = 1'b0;
      MemWrite  = 1'b0;
      Address   = 32'd0;
      WriteData = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_err", {31'd0, addr_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Preload words 0..15 through the write port, then sweep the first eight
      for (int i = 0; i < 16; i++)
         do_cycle("preload", 1'b1, AW'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101);
      for (int i = 0; i < 8; i++) begin
         read_chk("sweep", AW'(i));
         #19;
      end

      do_cycle("wr8", 1'b1, 32'd8, 32'd20);
      check_eq("wr8_val", ReadData, 32'd20);
      for (int i = 0; i < 8; i++) read_chk("wr8_others", AW'(i));

      do_cycle("fwd4", 1'b1, 32'd4, 32'hA5A5_A5A5);
      check_eq("fwd4_val", ReadData, 32'hA5A5_A5A5);

      do_cycle("nowe5", 1'b0, 32'd5, 32'hDEAD_BEEF);

      do_cycle("oor256", 1'b1, 32'd256, 32'd5);
      check_eq("oor256_rd", ReadData, 32'd0);
      check_eq("oor256_flag", {31'd0, addr_err}, 32'd1);
      do_cycle("oor_hold", 1'b0, 32'd2, 32'd0);
      do_cycle("oor_max", 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
      for (int i = 0; i < 16; i++) read_chk("oor_unchanged", AW'(i));

      // Reset clears the flag, blocks writes, keeps the array and its reads
      @(negedge clk);
      rst_n = 1'b0;
      do_cycle("rst_wr3", 1'b1, 32'd3, 32'hFFFF_FFFF);
      check_eq("rst_flag", {31'd0, addr_err}, 32'd0);
      read_chk("rst_rd7", 32'd7);
      @(negedge clk);
      rst_n = 1'b1;
      do_cycle("rel_wr3", 1'b1, 32'd3, 32'hFFFF_FFFF);
      check_eq("rel_wr3_val", ReadData, 32'hFFFF_FFFF);

      // Back-to-back writes on consecutive edges; last one wins
      do_cycle("b2b_a", 1'b1, 32'd10, 32'h0000_0001);
      do_cycle("b2b_b", 1'b1, 32'd10, 32'h0000_0002);
      do_cycle("b2b_c", 1'b1, 32'd10, 32'h0000_0003);
      check_eq("b2b_last", ReadData, 32'h0000_0003);

      // Random traffic over the initialised region and just beyond the top
      for (int i = 0; i < 60; i++) begin
         a = (($urandom_range(0, 9) == 0) ? 32'd256 + 32'($urandom_range(0, 3))
                                          : 32'($urandom_range(0, 15)));
         do_cycle("rand", 1'($urandom_range(0, 1)), a, $urandom);
      end
      for (int i = 0; i < 16; i++) read_chk("final", AW'(i));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter: DEPTH, default 256, number of 32-bit words held in the array.
REQ-002 Parameter: AW, default 32, Address port width; only word index bits are decoded.
REQ-003 Port: clk  input  1  rising-edge clock for all writes and registered state.
REQ-004 Port: rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 Port: ReadData  output  32  read data for word at Address.
REQ-006 Port: Address  input  AW  word index (not byte address); word n = data[n].
REQ-007 Port: WriteData  input  32  data written when MemWrite is high.
REQ-008 Port: MemWrite  input  1  write enable, sampled on rising clk.
REQ-009 Port: addr_err  output  1  sticky flag for an out-of-range write attempt.
REQ-010 Port order SHALL be ReadData, Address, WriteData, MemWrite, clk, rst_n, addr_err; the first five are used positionally by existing instantiations.
REQ-011 Storage SHALL be an unpacked array named data, reg [31:0] data[0:DEPTH-1], hierarchically reachable for $readmemb/$writememb preload and dump.

Function
REQ-012 Read SHALL be combinational (asynchronous): ReadData = data[Address] within the same delta, no clock latency.
REQ-013 Address >= DEPTH on read SHALL drive ReadData = 32'h0.
REQ-014 Write SHALL occur on rising clk when MemWrite=1, rst_n=1 and Address < DEPTH: data[Address] <= WriteData.
REQ-015 Write with Address >= DEPTH SHALL leave the array unchanged and set addr_err=1 at that edge.
REQ-016 addr_err SHALL remain 1 until reset; it SHALL be a registered output.
REQ-017 MemWrite=0 SHALL never modify the array, regardless of Address/WriteData.
REQ-018 Without forwarding (see Configuration), ReadData for the address being written SHALL show old contents until the write edge, then the new value.
REQ-019 Back-to-back writes to the same address on consecutive edges SHALL each take effect; the last write wins.
REQ-020 Array contents are X/undefined at power-up unless preloaded; the module SHALL contain no initial block clearing data.

Reset
REQ-021 On rising clk with rst_n=0: addr_err <= 0 and any write is suppressed.
REQ-022 Reset SHALL NOT clear or alter array contents (preloaded data survives reset).
REQ-023 ReadData SHALL remain a valid combinational read during reset.
REQ-024 Deassertion mid-operation: first rising clk with rst_n=1 and MemWrite=1 SHALL perform the write normally.

Configuration
REQ-025 Macro DATA_MEMORY_WR_FORWARD_EN: when defined, ReadData SHALL equal WriteData while MemWrite=1, rst_n=1 and Address < DEPTH (write-through forwarding before the edge); when undefined, ReadData always reflects stored contents (REQ-018).

Verification
REQ-026 Preload data[0..7] from file, MemWrite=0, step Address 0..7 every 20 ns -> ReadData equals each preloaded word, array unchanged.
REQ-027 MemWrite=1, Address=8, WriteData=20, one rising clk -> data[8]=32'd20, ReadData=20 after edge; dumped file differs only at word 8.
REQ-028 MemWrite=1, Address=DEPTH (256), WriteData=5, clk edge -> array unchanged, ReadData=0, addr_err=1 and held; rst_n=0 for one edge -> addr_err=0.
REQ-029 rst_n=0 with MemWrite=1, Address=3, WriteData=32'hFFFF_FFFF -> data[3] unchanged after edge; release reset, repeat -> data[3]=32'hFFFF_FFFF.
REQ-030 Address=4, MemWrite=1, WriteData=32'hA5A5_A5A5 before edge -> ReadData = old data[4] without macro, 32'hA5A5_A5A5 with DATA_MEMORY_WR_FORWARD_EN; both show 32'hA5A5_A5A5 after edge.
